// File: rtl/issue_sequencer_pkg.sv
// Shared types and constants for the dual-issue sequencer.
package issue_sequencer_pkg;

  typedef enum logic {
    StFresh,
    StSecond
  } seq_state_e;

  localparam logic [1:0] WWF_PAIR       = 2'b00;
  localparam logic [1:0] WWF_FIRST_DONE = 2'b01;
  localparam logic [1:0] WWF_SLOT1_DEAD = 2'b10;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

endpackage

// File: rtl/issue_perf_counters.sv
// Wrapping 32-bit counters of dual, single and empty issue cycles.
module issue_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_dual,
  input  logic        issue_single,
  output logic [31:0] perf_dual,
  output logic [31:0] perf_single,
  output logic [31:0] perf_bubble
);

  logic [31:0] dual_q, dual_d;
  logic [31:0] single_q, single_d;
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    dual_d   = dual_q;
    single_d = single_q;
    bubble_d = bubble_q;
    if (issue_dual) begin
      dual_d = dual_q + 32'd1;
    end else if (issue_single) begin
      single_d = single_q + 32'd1;
    end else begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dual_q   <= '0;
      single_q <= '0;
      bubble_q <= '0;
    end else begin
      dual_q   <= dual_d;
      single_q <= single_d;
      bubble_q <= bubble_d;
    end
  end

  assign perf_dual   = dual_q;
  assign perf_single = single_q;
  assign perf_bubble = bubble_q;

endmodule

// File: rtl/issue_sequencer.sv
// Dual-issue sequencer routing a fetched pair onto the even/odd pipes.
// Define ISSUE_PERF_CNT_EN to build the performance counters.
module issue_sequencer
  import issue_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pair_valid,
  input  logic [PC_W-1:0]    pair_pc,
  input  logic [INSTR_W-1:0] instr1,
  input  logic [INSTR_W-1:0] instr2,
  input  logic               instr1_type,
  input  logic               instr2_type,
  input  logic               stall,
  input  logic               dependent_stall,
  input  logic               flush,
  output logic               fetch_hold,
  output logic [1:0]         who_went_first,
  output logic               even_valid,
  output logic               odd_valid,
  output logic [INSTR_W-1:0] even_instr,
  output logic [INSTR_W-1:0] odd_instr,
  output logic [PC_W-1:0]    even_pc,
  output logic [PC_W-1:0]    odd_pc,
  output logic [31:0]        perf_dual,
  output logic [31:0]        perf_single,
  output logic [31:0]        perf_bubble
);

  seq_state_e state_q, state_d;

  logic               even_valid_q, even_valid_d;
  logic               odd_valid_q, odd_valid_d;
  logic [INSTR_W-1:0] even_instr_q, even_instr_d;
  logic [INSTR_W-1:0] odd_instr_q, odd_instr_d;
  logic [PC_W-1:0]    even_pc_q, even_pc_d;
  logic [PC_W-1:0]    odd_pc_q, odd_pc_d;

  logic            slot1_ok;
  logic [PC_W-1:0] pc2;
  logic            issue1;
  logic            issue2;

  // A pair fetched at an odd word address has no usable instr1 slot.
  assign slot1_ok = ~pair_pc[2];
  assign pc2      = pair_pc + PC_W'(4);

  always_comb begin
    if (state_q == StSecond) begin
      who_went_first = WWF_FIRST_DONE;
    end else if (slot1_ok) begin
      who_went_first = WWF_PAIR;
    end else begin
      who_went_first = WWF_SLOT1_DEAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_hold = 1'b0;
    issue1     = 1'b0;
    issue2     = 1'b0;
    if (flush) begin
      state_d = StFresh;
    end else if (stall) begin
      fetch_hold = 1'b1;
    end else if (!pair_valid) begin
      state_d = state_q;
    end else if (state_q == StSecond) begin
      issue2  = 1'b1;
      state_d = StFresh;
    end else if (!slot1_ok) begin
      issue2 = 1'b1;
    end else if (dependent_stall || (instr1_type == instr2_type)) begin
      // Never put two instructions on one pipe in a cycle: split the pair.
      issue1     = 1'b1;
      fetch_hold = 1'b1;
      state_d    = StSecond;
    end else begin
      issue1 = 1'b1;
      issue2 = 1'b1;
    end
    if (reset) begin
      fetch_hold = 1'b0;
    end
  end

  always_comb begin
    even_valid_d = 1'b0;
    odd_valid_d  = 1'b0;
    even_instr_d = even_instr_q;
    odd_instr_d  = odd_instr_q;
    even_pc_d    = even_pc_q;
    odd_pc_d     = odd_pc_q;
    if (issue1) begin
      if (instr1_type == PIPE_ODD) begin
        odd_valid_d = 1'b1;
        odd_instr_d = instr1;
        odd_pc_d    = pair_pc;
      end else begin
        even_valid_d = 1'b1;
        even_instr_d = instr1;
        even_pc_d    = pair_pc;
      end
    end
    if (issue2) begin
      if (instr2_type == PIPE_ODD) begin
        odd_valid_d = 1'b1;
        odd_instr_d = instr2;
        odd_pc_d    = pc2;
      end else begin
        even_valid_d = 1'b1;
        even_instr_d = instr2;
        even_pc_d    = pc2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFresh;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      even_instr_q <= '0;
      odd_instr_q  <= '0;
      even_pc_q    <= '0;
      odd_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      even_instr_q <= even_instr_d;
      odd_instr_q  <= odd_instr_d;
      even_pc_q    <= even_pc_d;
      odd_pc_q     <= odd_pc_d;
    end
  end

  assign even_valid = even_valid_q;
  assign odd_valid  = odd_valid_q;
  assign even_instr = even_instr_q;
  assign odd_instr  = odd_instr_q;
  assign even_pc    = even_pc_q;
  assign odd_pc     = odd_pc_q;

`ifdef ISSUE_PERF_CNT_EN
  logic issue_dual;
  logic issue_single;

  assign issue_dual   = issue1 & issue2;
  assign issue_single = issue1 ^ issue2;

  issue_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .issue_dual  (issue_dual),
    .issue_single(issue_single),
    .perf_dual   (perf_dual),
    .perf_single (perf_single),
    .perf_bubble (perf_bubble)
  );
`else
  assign perf_dual   = '0;
  assign perf_single = '0;
  assign perf_bubble = '0;
`endif

endmodule
